uart_tx_byte_fifo: RTL

Transmit-side byte buffer and launch sequencer directly upstream of the UART controller's TX path. It accepts bytes from a host write port into a circular FIFO, then presents them one at a time on the controller's i_Tx_Ready/i_Tx_Byte inputs. It waits for the controller's o_Tx_Active/o_Tx_Done feedback before launching the next byte. A watchdog recovers from a stalled controller. All logic runs in the single system clock domain; controller feedback is delivered synchronous to clk.

---
 rtl/uart_tx_byte_fifo.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_byte_fifo.sv
// Host-side TX byte FIFO plus launch sequencer in front of the UART TX controller.
// Bytes are popped one at a time, handed over on Tx_Ready/Tx_Byte, and a watchdog drops a stalled frame.
module uart_tx_byte_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Wr_En,
  input  logic [7:0]            i_Wr_Byte,
  input  logic                  i_Flush,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Tx_Ready,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_Error,
  output logic                  o_Busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, GAP} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            byte_q, byte_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  done_prev_q, done_seen_q, done_seen_d;
  logic                  ovf_q, ovf_d, err_q, err_d;
  logic                  full, empty, wr_acc, pop, done_edge, timeout;

  assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_acc    = i_Wr_En & ~full & ~i_Flush;
  assign pop       = (state_q == IDLE) & ~empty & ~i_Flush;
  assign done_edge = i_Tx_Done & ~done_prev_q;
  assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Flush wins over a same-cycle write and suppresses the overflow pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = i_Wr_En & full & ~i_Flush;
    if (i_Flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  // Timer is shared by the watchdog (REQ/WAIT_DONE) and the inter-frame gap; it clears on every state entry.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    timer_d     = timer_q + TW'(1);
    done_seen_d = done_seen_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pop) begin
          byte_d      = mem_q[rd_ptr_q];
          done_seen_d = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (done_edge) done_seen_d = 1'b1;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (i_Tx_Active) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end
      end
      WAIT_DONE: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          timer_d = '0;
        end else if (done_edge | done_seen_q) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        if (GAP_CYCLES == 0 || timer_q == TW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      byte_q      <= 8'h00;
      timer_q     <= '0;
      done_prev_q <= 1'b0;
      done_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      byte_q      <= byte_d;
      timer_q     <= timer_d;
      done_prev_q <= i_Tx_Done;
      done_seen_q <= done_seen_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_Ready = (state_q == REQ);
  assign o_Tx_Byte  = byte_q;
  assign o_Tx_Error = err_q;
  assign o_Busy     = (state_q != IDLE);
endmodule
